// File: rtl/md_unit.sv
// md_unit: multiply/divide unit that owns HI/LO for the E stage.
// mult/multu/div/divu take a fixed number of busy cycles and then commit HI/LO.
// mthi/mtlo write their register in one cycle. stall_md asks the hazard unit
// to hold D whenever the D-stage instruction needs HI/LO while this unit is occupied.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_D,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_md
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   res_q, res_d;
  logic                  dz_q, dz_d;
  logic                  busy_q, busy_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;

  logic signed [2*DATA_W-1:0] a_sx, b_sx, prod_s;
  logic [2*DATA_W-1:0]        a_zx, b_zx, prod_u;
  logic                       b_zero;
  logic [DATA_W-1:0]          divisor;
  logic signed [DATA_W-1:0]   a_s, d_s, quot_s, rem_s;
  logic [DATA_W-1:0]          quot_u, rem_u;

  // Single-cycle datapath: both products and both divisions of a by b
  always_comb begin
    a_sx    = {{DATA_W{a[DATA_W-1]}}, a};
    b_sx    = {{DATA_W{b[DATA_W-1]}}, b};
    prod_s  = a_sx * b_sx;
    a_zx    = {{DATA_W{1'b0}}, a};
    b_zx    = {{DATA_W{1'b0}}, b};
    prod_u  = a_zx * b_zx;
    b_zero  = (b == '0);
    // A zero divisor is replaced by 1 so the divider never produces X;
    // the result is discarded at commit anyway.
    divisor = b_zero ? DATA_W'(1) : b;
    a_s     = a;
    d_s     = divisor;
    quot_s  = a_s / d_s;
    rem_s   = a_s % d_s;
    quot_u  = a / divisor;
    rem_u   = a % divisor;
  end

  // Next-state logic: op launch in IDLE, countdown and commit in BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdop)
            OP_MULT: begin
              res_d   = prod_s;
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = BUSY;
              busy_d  = 1'b1;
            end
            OP_MULTU: begin
              res_d   = prod_u;
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = BUSY;
              busy_d  = 1'b1;
            end
            OP_DIV: begin
              res_d   = {rem_s, quot_s};
              dz_d    = b_zero;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = BUSY;
              busy_d  = 1'b1;
            end
            OP_DIVU: begin
              res_d   = {rem_u, quot_u};
              dz_d    = b_zero;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = BUSY;
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // start is ignored here; the stall protocol keeps it from happening
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          if (!dz_q) begin
            hi_d = res_q[2*DATA_W-1:DATA_W];
            lo_d = res_q[DATA_W-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  // Combinational so the hazard unit sees the launch cycle as well
  assign stall_md = md_D & (start | busy_q);

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit with built-in sequencing for the pipelined MIPS core. It sits in the E stage beside the ALU and owns the HI/LO registers. It runs mult/multu/div/divu as fixed-latency multi-cycle operations and executes mthi/mtlo in a single cycle. It raises a stall request that the hazard unit ORs into its global stall whenever the D-stage instruction needs HI/LO while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu (legal range 1–15).
- DIV_CYCLES, default 10: busy cycles for div/divu (legal range 1–15).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- start  in  1  E-stage instruction is an MDU op; qualifies mdop; held for exactly one cycle per instruction.
- mdop  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- a  in  32  forwarded rs value (E stage).
- b  in  32  forwarded rt value (E stage).
- md_D  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- busy  out  1  multi-cycle operation in progress.
- hi  out  32  HI register.
- lo  out  32  LO register.
- stall_md  out  1  stall request to hazard unit.

## Operation
- States: IDLE, BUSY. The counter cnt is 4 bits wide. A pending result register res (64 bits) holds the HI:LO value to commit.
- IDLE + start + mdop in {1..4}:
  - Compute the result from a and b this cycle and latch it into res.
  - Load cnt with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
  - Go to BUSY.
- Arithmetic rules:
  - mult: signed 32×32 → 64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32×32 → 64, same split.
  - div: signed division; LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - divu: unsigned division; LO = quotient, HI = remainder.
  - Divide by zero (b == 0): the operation still occupies DIV_CYCLES busy cycles, and HI/LO are left unchanged at commit.
- BUSY: cnt decrements each cycle. In the cycle where cnt == 1, HI/LO load from res at the closing edge (unless the op was a divide by zero), and the state returns to IDLE.
- IDLE + start + mdop 5/6: HI (mthi) or LO (mtlo) loads a at the closing edge. The unit does not enter BUSY.
- start while BUSY is ignored: no state change and no HI/LO write. The stall_md protocol makes this unreachable in a correct pipeline, and the bench checks it anyway.
- stall_md = md_D & (start | busy). The signal is combinational and carries no register.
- hi and lo are driven straight from their registers, so mfhi/mflo read them combinationally in E.

## Timing
- Reset values: state IDLE, cnt 0, busy 0, hi 0, lo 0, res 0. stall_md evaluates to md_D & start.
- For an MD op with start in cycle t:
  - busy is 1 in cycles t+1 … t+N, where N is the relevant parameter.
  - New HI/LO are visible from cycle t+N+1, the same cycle in which busy returns to 0.
- mthi/mtlo with start in cycle t: the new value is visible from t+1, and busy stays 0.
- Back-to-back MD ops: a second start may be accepted in cycle t+N+1 at the earliest. This gives N+1 cycles between accepted starts.
- Reset asserted mid-operation: at the next edge every register returns to its reset value, and the pending result is discarded (HI/LO are 0, not the result).
- reset and start in the same cycle: reset wins.

## Test plan
- multu with a=0xFFFFFFFF, b=0x00000002, start at t → busy is high for exactly 5 cycles (t+1..t+5); at t+6, hi=0x00000001 and lo=0xFFFFFFFE.
- mult with a=0xFFFFFFFD (−3), b=5 → after 5 busy cycles, hi=0xFFFFFFFF and lo=0xFFFFFFF1.
- div with a=0xFFFFFFF9 (−7), b=2 → 10 busy cycles; then lo=0xFFFFFFFD and hi=0xFFFFFFFF. divu with a=7, b=0 → 10 busy cycles, and hi/lo keep their prior values.
- mthi with a=0x12345678 at t → hi=0x12345678 at t+1 and busy stays 0. Then a mult is started, and mtlo is issued with start during busy → lo is unaffected by the mtlo; stall_md=1 whenever md_D=1 during the busy window.
- md_D=1 in the same cycle as start of a div → stall_md=1 in that cycle and through t+10, and 0 at t+11.
- A mult is started and reset is asserted at t+3 → at t+4, busy=0 and hi=lo=0, and no commit occurs at t+6.
